regfile_cmd_ctrl: RTL and testbench

- Command front-end that sits directly upstream of the register file.
- Consumes a byte stream from the UART RX path, decodes write/read command frames and drives the register file's WrEn/RdEn/Address/WrData.
- On reads, captures RdData and forwards it as one byte to the UART TX path over a valid/busy handshake.

---
 rtl/regfile_cmd_ctrl_pkg.sv | 24 ++
 rtl/regfile_cmd_ctrl_if.sv | 37 +++
 rtl/regfile_cmd_ctrl.sv | 104 ++++++++++
 tb/tb_regfile_cmd_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_cmd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_cmd_pkg
// Description : Shared opcodes, error byte and FSM state encoding for the
//               register-file command front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_cmd_pkg;

  localparam logic [7:0] CMD_WR   = 8'hAA;
  localparam logic [7:0] CMD_RD   = 8'hBB;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } state_t;

endpackage : regfile_cmd_pkg
`default_nettype wire

// File: rtl/regfile_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_cmd_ctrl_if
// Description : Bundle of UART RX/TX handshake and register-file signals seen
//               by the command front-end. slave = controller side,
//               master = environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_cmd_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 3
);

  logic [WIDTH-1:0] RX_Data;
  logic             RX_Valid;
  logic [WIDTH-1:0] RdData;
  logic             WrEn;
  logic             RdEn;
  logic [ADDR-1:0]  Address;
  logic [WIDTH-1:0] WrData;
  logic [WIDTH-1:0] TX_Data;
  logic             TX_Valid;
  logic             TX_Busy;
  logic             Busy;

  modport slave (
    input  RX_Data, RX_Valid, RdData, TX_Busy,
    output WrEn, RdEn, Address, WrData, TX_Data, TX_Valid, Busy
  );

  modport master (
    output RX_Data, RX_Valid, RdData, TX_Busy,
    input  WrEn, RdEn, Address, WrData, TX_Data, TX_Valid, Busy
  );

endinterface : regfile_cmd_ctrl_if
`default_nettype wire

// File: rtl/regfile_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_cmd_ctrl
// Description : Decodes AA/BB command frames from the UART RX byte stream,
//               drives register-file write/read strobes and returns read data
//               as one byte over the TX valid/busy handshake.
//               Optional macro REGFILE_CMD_ERR_RESP_EN: unknown opcodes in
//               IDLE are answered with ERR_BYTE instead of being dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_cmd_ctrl
  import regfile_cmd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ADDR  = 3
) (
  input  wire logic          clk,
  input  wire logic          rst,
  regfile_cmd_ctrl_if.slave  bus
);

  state_t r_state;

  // Command FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      bus.WrEn     <= 1'b0;
      bus.RdEn     <= 1'b0;
      bus.Address  <= '0;
      bus.WrData   <= '0;
      bus.TX_Data  <= '0;
      bus.TX_Valid <= 1'b0;
      bus.Busy     <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      bus.WrEn <= 1'b0;
      bus.RdEn <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.RX_Valid) begin
            if (bus.RX_Data == WIDTH'(CMD_WR)) begin
              r_state  <= WR_ADDR;
              bus.Busy <= 1'b1;
            end else if (bus.RX_Data == WIDTH'(CMD_RD)) begin
              r_state  <= RD_ADDR;
              bus.Busy <= 1'b1;
            end
`ifdef REGFILE_CMD_ERR_RESP_EN
            else begin
              bus.TX_Data  <= WIDTH'(ERR_BYTE);
              bus.TX_Valid <= 1'b1;
              r_state      <= TX_SEND;
              bus.Busy     <= 1'b1;
            end
`endif
          end
        end
        WR_ADDR: begin
          if (bus.RX_Valid) begin
            bus.Address <= bus.RX_Data[ADDR-1:0];
            r_state     <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (bus.RX_Valid) begin
            bus.WrData <= bus.RX_Data;
            bus.WrEn   <= 1'b1;
            r_state    <= IDLE;
            bus.Busy   <= 1'b0;
          end
        end
        RD_ADDR: begin
          // Stay here for the RdEn cycle so RD_WAIT lines up with the
          // cycle in which the register file presents RdData.
          if (bus.RdEn) begin
            r_state <= RD_WAIT;
          end else if (bus.RX_Valid) begin
            bus.Address <= bus.RX_Data[ADDR-1:0];
            bus.RdEn    <= 1'b1;
          end
        end
        RD_WAIT: begin
          bus.TX_Data  <= bus.RdData;
          bus.TX_Valid <= 1'b1;
          r_state      <= TX_SEND;
        end
        TX_SEND: begin
          if (!bus.TX_Busy) begin
            bus.TX_Valid <= 1'b0;
            r_state      <= IDLE;
            bus.Busy     <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          bus.Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule : regfile_cmd_ctrl
`default_nettype wire

// File: tb/tb_regfile_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_cmd_ctrl
// Description : Self-checking bench for regfile_cmd_ctrl: directed frames
//               with cycle-exact checks, then random frames compared against
//               a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_cmd_ctrl;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  regfile_cmd_ctrl_if #(.WIDTH(8), .ADDR(3)) bus ();

  regfile_cmd_ctrl #(.WIDTH(8), .ADDR(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file behind the controller: read data appears the cycle after RdEn.
  logic [7:0] rf [8];
  logic [7:0] rd_q;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
      rd_q <= 8'h00;
    end else begin
      if (bus.WrEn) rf[bus.Address] <= bus.WrData;
      if (bus.RdEn) rd_q <= rf[bus.Address];
    end
  end
  assign bus.RdData = rd_q;

  // Observed transactions.
  logic [10:0] obs_wr[$];
  logic [2:0]  obs_rd[$];
  logic [7:0]  obs_tx[$];
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.WrEn) obs_wr.push_back({bus.Address, bus.WrData});
      if (bus.RdEn) obs_rd.push_back(bus.Address);
      if (bus.TX_Valid && !bus.TX_Busy) obs_tx.push_back(bus.TX_Data);
    end
  end

  // Frame-level reference model state.
  logic [7:0]  m_mem[8];
  logic [10:0] exp_wr[$];
  logic [2:0]  exp_rd[$];
  logic [7:0]  exp_tx[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.RX_Data  = b;
    bus.RX_Valid = 1'b1;
    tick();
    bus.RX_Valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wren"},    32'(bus.WrEn),     32'd0);
    chk({tag, "_rden"},    32'(bus.RdEn),     32'd0);
    chk({tag, "_addr"},    32'(bus.Address),  32'd0);
    chk({tag, "_wrdata"},  32'(bus.WrData),   32'd0);
    chk({tag, "_txdata"},  32'(bus.TX_Data),  32'd0);
    chk({tag, "_txvalid"}, 32'(bus.TX_Valid), 32'd0);
    chk({tag, "_busy"},    32'(bus.Busy),     32'd0);
  endtask

  task automatic write_check(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'hAA);
    send_byte(a);
    send_byte(d);
    chk("wr_wren",   32'(bus.WrEn),    32'd1);
    chk("wr_addr",   32'(bus.Address), 32'(a[2:0]));
    chk("wr_data",   32'(bus.WrData),  32'(d));
    chk("wr_rden",   32'(bus.RdEn),    32'd0);
    tick();
    chk("wr_wren_off", 32'(bus.WrEn),  32'd0);
  endtask

  task automatic read_check(input logic [7:0] a, input logic [7:0] d);
    bus.TX_Busy = 1'b0;
    send_byte(8'hBB);
    send_byte(a);
    chk("rd_rden",    32'(bus.RdEn),     32'd1);
    chk("rd_addr",    32'(bus.Address),  32'(a[2:0]));
    chk("rd_wren",    32'(bus.WrEn),     32'd0);
    tick();
    chk("rd_rden_off", 32'(bus.RdEn),    32'd0);
    chk("rd_txv_early", 32'(bus.TX_Valid), 32'd0);
    tick();
    chk("rd_txvalid", 32'(bus.TX_Valid), 32'd1);
    chk("rd_txdata",  32'(bus.TX_Data),  32'(d));
    tick();
    chk("rd_txv_off", 32'(bus.TX_Valid), 32'd0);
    chk("rd_busy_off", 32'(bus.Busy),    32'd0);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      bus.TX_Busy = 1'($urandom_range(0, 1));
      tick();
      if (!bus.Busy) begin
        done = 1'b1;
        break;
      end
    end
    bus.TX_Busy = 1'b0;
    chk("idle_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, d, g;
    int         kind;
    rst          = 1'b1;
    bus.RX_Data  = 8'h00;
    bus.RX_Valid = 1'b0;
    bus.TX_Busy  = 1'b0;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Reset mid-frame discards the partial write.
    send_byte(8'hAA);
    send_byte(8'h05);
    chk("mid_busy", 32'(bus.Busy), 32'd1);
    rst = 1'b1;
    tick();
    tick();
    check_zero("midrst");
    rst = 1'b0;
    read_check(8'h05, 8'h00);
    chk("stale_write", 32'(obs_wr.size()), 32'd0);

    // Writes and read-back.
    write_check(8'h07, 8'h01);
    write_check(8'h01, 8'h1C);
    write_check(8'h05, 8'h0A);
    read_check(8'h05, 8'h0A);
    read_check(8'h01, 8'h1C);
    read_check(8'h07, 8'h01);

    // TX backpressure with a dropped RX byte.
    bus.TX_Busy = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h01);
    tick();
    tick();
    chk("bp_txvalid", 32'(bus.TX_Valid), 32'd1);
    chk("bp_txdata",  32'(bus.TX_Data),  32'h1C);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) send_byte(8'hAA);
      else tick();
      chk("bp_hold_valid", 32'(bus.TX_Valid), 32'd1);
      chk("bp_hold_data",  32'(bus.TX_Data),  32'h1C);
    end
    bus.TX_Busy = 1'b0;
    tick();
    chk("bp_release", 32'(bus.TX_Valid), 32'd0);
    chk("bp_idle",    32'(bus.Busy),     32'd0);
    read_check(8'h07, 8'h01);

    // Edge bytes: upper address bits ignored, opcode value as data.
    write_check(8'hFD, 8'hBB);
    read_check(8'h05, 8'hBB);
    send_byte(8'h3C);
    chk("unk_wren", 32'(bus.WrEn), 32'd0);
    chk("unk_rden", 32'(bus.RdEn), 32'd0);
`ifdef REGFILE_CMD_ERR_RESP_EN
    chk("unk_txvalid", 32'(bus.TX_Valid), 32'd1);
    chk("unk_txdata",  32'(bus.TX_Data),  32'hEE);
    chk("unk_busy",    32'(bus.Busy),     32'd1);
    tick();
    chk("unk_done",    32'(bus.Busy),     32'd0);
`else
    chk("unk_txvalid", 32'(bus.TX_Valid), 32'd0);
    chk("unk_busy",    32'(bus.Busy),     32'd0);
`endif

    // Back-to-back frames with no gap.
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h33);
    chk("b2b_wren", 32'(bus.WrEn), 32'd1);
    send_byte(8'hBB);
    chk("b2b_wren_off", 32'(bus.WrEn), 32'd0);
    chk("b2b_busy",     32'(bus.Busy), 32'd1);
    send_byte(8'h02);
    chk("b2b_rden", 32'(bus.RdEn),    32'd1);
    chk("b2b_addr", 32'(bus.Address), 32'd2);
    tick();
    tick();
    chk("b2b_txvalid", 32'(bus.TX_Valid), 32'd1);
    chk("b2b_txdata",  32'(bus.TX_Data),  32'h33);
    tick();

    // Random frames against the frame-level model.
    obs_wr.delete();
    obs_rd.delete();
    obs_tx.delete();
    for (int i = 0; i < 8; i++) begin
      a = 8'(($urandom_range(0, 31) << 3) | i);
      d = 8'($urandom);
      send_byte(8'hAA);
      send_byte(a);
      send_byte(d);
      m_mem[i] = d;
      exp_wr.push_back({a[2:0], d});
    end
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 3));
      a = 8'($urandom);
      d = 8'($urandom);
      if (kind <= 1) begin
        send_byte(8'hAA);
        send_byte(a);
        send_byte(d);
        m_mem[a[2:0]] = d;
        exp_wr.push_back({a[2:0], d});
        for (int w = 0; w < int'($urandom_range(0, 2)); w++) tick();
      end else if (kind == 2) begin
        send_byte(8'hBB);
        send_byte(a);
        exp_rd.push_back(a[2:0]);
        exp_tx.push_back(m_mem[a[2:0]]);
        wait_idle();
      end else begin
        g = 8'($urandom);
        if (g == 8'hAA || g == 8'hBB) g = 8'h3C;
        send_byte(g);
`ifdef REGFILE_CMD_ERR_RESP_EN
        exp_tx.push_back(8'hEE);
`endif
        wait_idle();
      end
    end
    tick();
    tick();

    chk("rnd_wr_count", 32'(obs_wr.size()), 32'(exp_wr.size()));
    chk("rnd_rd_count", 32'(obs_rd.size()), 32'(exp_rd.size()));
    chk("rnd_tx_count", 32'(obs_tx.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
      chk("rnd_wr", 32'(obs_wr[i]), 32'(exp_wr[i]));
    for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
      chk("rnd_rd", 32'(obs_rd[i]), 32'(exp_rd[i]));
    for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++)
      chk("rnd_tx", 32'(obs_tx[i]), 32'(exp_tx[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_regfile_cmd_ctrl
`default_nettype wire
